// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, loadable instruction memory and a
// valid/ready output register toward ID, with redirect/flush, program-load
// mode and HALT / out-of-range detection.
module if_fetch_unit #(
    parameter int unsigned            NB_ADDR   = 32,
    parameter int unsigned            NB_INST   = 32,
    parameter int unsigned            MEM_DEPTH = 256,
    parameter int unsigned            PC_STEP   = 4,
    parameter logic [NB_ADDR-1:0]     RESET_PC  = '0,
    parameter logic [NB_INST-1:0]     HALT_INST = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_write,
    input  logic [NB_ADDR-1:0] i_address,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic               i_start,
    input  logic               i_redirect,
    input  logic [NB_ADDR-1:0] i_redirect_pc,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_pc,
    output logic               o_halt,
    output logic               o_fault
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t               state;
    logic [NB_ADDR-1:0]   pc;
    logic [NB_ADDR-1:0]   pc_seq;
    logic [NB_INST-1:0]   mem [MEM_DEPTH];
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 in_range;
    logic                 advance;
    logic [NB_INST-1:0]   fetch_word;
    logic                 addr_unused;

    // Only the word-index field of the write address selects a location.
    assign addr_unused = ^i_address;
    assign wr_idx      = i_address[2 +: IDX_W];
    assign rd_idx      = pc[2 +: IDX_W];
    assign pc_seq      = pc + NB_ADDR'(PC_STEP);
    assign in_range    = (pc >> 2) < NB_ADDR'(MEM_DEPTH);
    assign advance     = i_enable & (~o_valid | i_ready);

    // Fetch source: memory word, or HALT_INST when the PC is past the end.
    always_comb begin
        fetch_word = HALT_INST;
        if (in_range) begin
            fetch_word = mem[rd_idx];
        end
    end

    // Program loading; memory is not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset && state == ST_LOAD && i_write) begin
            mem[wr_idx] <= i_instruction;
        end
    end

    // Fetch control: state, PC and the registered output toward ID.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state         <= ST_LOAD;
            pc            <= RESET_PC;
            o_valid       <= 1'b0;
            o_instruction <= '0;
            o_pc          <= '0;
            o_halt        <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (i_start) begin
                        state <= ST_RUN;
                        pc    <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    if (i_enable && i_redirect) begin
                        // Redirect wins over advance and flushes the wrong-path word.
                        pc      <= i_redirect_pc;
                        o_valid <= 1'b0;
                    end else if (advance) begin
                        o_instruction <= fetch_word;
                        o_pc          <= pc_seq;
                        o_valid       <= 1'b1;
                        if (!in_range) begin
                            o_fault <= 1'b1;
                            o_halt  <= 1'b1;
                            state   <= ST_HALT;
                        end else if (fetch_word == HALT_INST) begin
                            o_halt <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc <= pc_seq;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_enable && i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected transfers,
// a negedge monitor pops and compares every accepted output.
module tb_if_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_write = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_instruction = '0;
    logic        i_start = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_ready = 1'b0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_halt;
    logic        o_fault;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        halt;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    if_fetch_unit #(
        .NB_ADDR  (32),
        .NB_INST  (32),
        .MEM_DEPTH(256),
        .PC_STEP  (4),
        .RESET_PC (32'h0),
        .HALT_INST(32'hFFFF_FFFF)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_instruction(i_instruction),
        .i_start      (i_start),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_instruction(o_instruction),
        .o_pc         (o_pc),
        .o_halt       (o_halt),
        .o_fault      (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                        input logic halt, input logic fault);
        exp_t x;
        x.inst  = inst;
        x.pc    = pc;
        x.halt  = halt;
        x.fault = fault;
        sb.push_back(x);
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic start);
        i_write       = 1'b1;
        i_address     = addr;
        i_instruction = data;
        i_start       = start;
        tick();
        i_write = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_inst"},  64'(o_instruction), 64'd0);
        check({tag, "_pc"},    64'(o_pc), 64'd0);
        check({tag, "_halt"},  64'(o_halt), 64'd0);
        check({tag, "_fault"}, 64'(o_fault), 64'd0);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
    endtask

    // Monitor: one accepted output per negedge where ID takes it.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset && i_enable && o_valid && i_ready && !i_redirect) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got inst %h pc %h, expected none",
                             o_instruction, o_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_inst",  64'(o_instruction), 64'(e.inst));
                    check("out_pc",    64'(o_pc), 64'(e.pc));
                    check("out_halt",  64'(o_halt), 64'(e.halt));
                    check("out_fault", 64'(o_fault), 64'(e.fault));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        check_reset_state("reset0");
        i_reset = 1'b1;
        i_ready = 1'b1;

        // Load program; last write coincides with start
        write_word(32'h000, 32'h2001_0005, 1'b0);
        write_word(32'h004, 32'h2002_0007, 1'b0);
        write_word(32'h008, HALT,          1'b0);
        write_word(32'h040, 32'h1111_1111, 1'b0);
        write_word(32'h044, 32'h2222_2222, 1'b0);
        write_word(32'h048, HALT,          1'b0);
        write_word(32'h3FC, 32'h3333_3333, 1'b1);
        check("first_fetch_gap", 64'(o_valid), 64'd0);

        // Straight-line run to HALT
        push(32'h2001_0005, 32'h4, 1'b0, 1'b0);
        push(32'h2002_0007, 32'h8, 1'b0, 1'b0);
        push(HALT,          32'hC, 1'b1, 1'b0);
        drain(10);
        check("run_halt_valid", 64'(o_valid), 64'd0);
        check("run_halt_halt",  64'(o_halt), 64'd1);
        check("run_halt_fault", 64'(o_fault), 64'd0);

        // Backpressure then redirect
        do_reset();
        check_reset_state("reset1");
        i_ready = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_inst",  64'(o_instruction), 64'h2001_0005);
            check("bp_pc",    64'(o_pc), 64'h4);
        end
        i_ready = 1'b1;
        push(32'h2001_0005, 32'h4, 1'b0, 1'b0);
        tick();
        check("pre_redirect_pc", 64'(o_pc), 64'h8);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        tick();
        i_redirect = 1'b0;
        check("redirect_bubble", 64'(o_valid), 64'd0);
        push(32'h1111_1111, 32'h44, 1'b0, 1'b0);
        push(32'h2222_2222, 32'h48, 1'b0, 1'b0);
        push(HALT,          32'h4C, 1'b1, 1'b0);
        drain(10);
        check("redir_halt", 64'(o_halt), 64'd1);

        // Frozen redirect is lost; writes during RUN are ignored; mid-run reset
        do_reset();
        i_start = 1'b1;
        tick();
        i_start       = 1'b0;
        i_enable      = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        i_write       = 1'b1;
        i_address     = 32'h0;
        i_instruction = 32'hDEAD_BEEF;
        tick();
        check("frozen_valid", 64'(o_valid), 64'd0);
        i_enable   = 1'b1;
        i_redirect = 1'b0;
        push(32'h2001_0005, 32'h4, 1'b0, 1'b0);
        tick();
        tick();
        i_write = 1'b0;
        i_reset = 1'b0;
        tick();
        check_reset_state("midrun");
        i_reset = 1'b1;
        check("midrun_sb_empty", 64'(sb.size()), 64'd0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        push(32'h2001_0005, 32'h4, 1'b0, 1'b0);
        push(32'h2002_0007, 32'h8, 1'b0, 1'b0);
        push(HALT,          32'hC, 1'b1, 1'b0);
        drain(10);

        // Last in-range word, then out-of-range fetch
        do_reset();
        i_start = 1'b1;
        tick();
        i_start       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h3FC;
        tick();
        i_redirect = 1'b0;
        push(32'h3333_3333, 32'h400, 1'b0, 1'b0);
        push(HALT,          32'h404, 1'b1, 1'b1);
        drain(10);
        check("oor_fault", 64'(o_fault), 64'd1);
        check("oor_halt",  64'(o_halt), 64'd1);
        check("oor_valid", 64'(o_valid), 64'd0);
        i_start       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0;
        tick();
        tick();
        i_start    = 1'b0;
        i_redirect = 1'b0;
        check("halt_sticky_valid", 64'(o_valid), 64'd0);
        check("halt_sticky_fault", 64'(o_fault), 64'd1);
        do_reset();
        check_reset_state("reset_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage for the MIPS pipeline. It holds the PC, an internal loadable instruction memory, and an output register with a valid/ready handshake toward ID. It also handles branch/jump redirect with flush, program-loading mode, and HALT detection. It sits between the debug loader/control unit and the IF/ID boundary, and replaces the fixed PC/memory/increment fetch path.

## Interface
- NB_ADDR, 32, PC/address width in bits
- NB_INST, 32, instruction width in bits
- MEM_DEPTH, 256, instruction memory depth in words (power of two)
- PC_STEP, 4, PC increment per fetched instruction (bytes)
- RESET_PC, 0, PC value after reset
- HALT_INST, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- i_clk  in  1  single clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_enable  in  1  global step enable (debug step/run); 0 freezes all fetch state
- i_write  in  1  memory write strobe, honoured only in ST_LOAD
- i_address  in  NB_ADDR  byte address for write; word index = i_address[2 +: log2(MEM_DEPTH)], low 2 bits ignored
- i_instruction  in  NB_INST  write data
- i_start  in  1  leave ST_LOAD, begin fetching at RESET_PC
- i_redirect  in  1  branch/jump taken, from ID/EX
- i_redirect_pc  in  NB_ADDR  redirect target
- i_ready  in  1  ID accepts current output
- o_valid  out  1  o_instruction/o_pc valid
- o_instruction  out  NB_INST  fetched instruction
- o_pc  out  NB_ADDR  address of fetched instruction + PC_STEP
- o_halt  out  1  HALT fetched; stays 1 until reset
- o_fault  out  1  fetch attempted with word index >= MEM_DEPTH; sticky until reset

## Operation
- States: ST_LOAD (reset state), ST_RUN, ST_HALT.
- ST_LOAD: a write when i_write=1 stores mem[idx] <= i_instruction. No fetch, and o_valid=0. i_start=1 moves to ST_RUN; if i_write and i_start coincide, the write still occurs.
- ST_RUN: advance = i_enable & (~o_valid | i_ready).
- On advance: o_instruction <= mem[pc index], o_pc <= pc+PC_STEP, o_valid <= 1, pc <= pc+PC_STEP.
- No advance: outputs and pc hold. If o_valid=1 and i_ready=0, outputs stay stable.
- Redirect (i_redirect=1 & i_enable=1, ST_RUN) has priority over advance: pc <= i_redirect_pc and o_valid <= 0 (flushes the wrong-path instruction). i_ready is ignored that cycle.
- HALT: on an advance whose fetched word == HALT_INST, the instruction is presented with o_valid=1 and o_halt <= 1. State moves to ST_HALT and pc holds.
- ST_HALT: no further fetch. o_valid clears when i_ready=1; redirect and i_start are ignored. Exit only by reset.
- Out-of-range fetch (pc index >= MEM_DEPTH): HALT_INST is presented instead, with o_fault <= 1 and o_halt <= 1, and state moves to ST_HALT.
- Writes in ST_RUN or ST_HALT are ignored.
- Arithmetic: pc+PC_STEP wraps modulo 2^NB_ADDR.
- Reset (i_reset=0, any state, mid-operation included): state=ST_LOAD, pc=RESET_PC, o_valid=0, o_instruction=0, o_pc=0, o_halt=0, o_fault=0. Memory contents are not cleared and persist across reset.

## Timing
- Fetch latency is 1 cycle: the advance edge loads the output register, and o_valid is visible after that edge.
- Throughput: 1 instruction/cycle with i_ready=1 and i_enable=1.
- First fetch: the edge with i_start moves to ST_RUN; the next edge presents mem[RESET_PC].
- Redirect: the redirect edge gives o_valid=0; the following edge presents mem[target]. That is a 1-bubble penalty.
- Writes complete at the edge. A write is readable by a fetch no earlier than the edge after ST_RUN entry.
- i_enable=0 freezes state, pc and outputs, including the redirect effect; a redirect asserted with i_enable=0 is lost.

## Test plan
- Reset/load: write 0x20010005 @0, 0x20020007 @4, HALT @8; pulse i_start; i_ready=1. Expect the o_instruction sequence 0x20010005, 0x20020007, 0xFFFFFFFF with o_pc 4, 8, 12, then o_halt=1 and o_valid=0 afterwards.
- Backpressure: hold i_ready=0 for 3 cycles after the first valid. o_instruction=0x20010005 and o_pc=4 stay stable, and pc does not advance.
- Redirect: assert i_redirect with target 0x40 while the output shows @4. Next cycle o_valid=0; the cycle after shows mem[16] with o_pc=0x44.
- Write outside ST_LOAD: i_write @0 with 0xDEADBEEF in ST_RUN. After reset+start, mem[0] is unchanged.
- Out of range with MEM_DEPTH=4: redirect to 0x10. Expect o_instruction=0xFFFFFFFF, o_fault=1, o_halt=1.
- Mid-run reset: i_reset=0 during ST_RUN. Next edge all outputs are 0 and state is ST_LOAD; after i_start, refetch from 0 returns the original program.
